led_uart_reporter: RTL and testbench
====================================

LED_UART_REPORTER -- requirements
Module: led_uart_reporter

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 25_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the UART bit rate in bit/s.
REQ-003 The block SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port leds  input  8  LED pattern from the upstream shifter, synchronous to clk (no synchronizer).
REQ-006 The block SHALL have port tx  output  1  UART serial line, idle high.
REQ-007 The block SHALL have port busy  output  1  high while a report frame is being transmitted.

Function
REQ-008 The block SHALL define DIV = CLK_FREQ / BAUD (integer division), with one bit period equal to exactly DIV clk cycles, and DIV >= 2 required.
REQ-009 The block SHALL hold an 8-bit last_sent register that is updated only when a frame starts.
REQ-010 In IDLE, at a rising edge where leds != last_sent, the block SHALL latch snap <= leds and last_sent <= leds, enter START, and drive tx=0 and busy=1 from the next cycle (1-cycle latency).
REQ-011 A report frame SHALL consist of 4 bytes in order: ASCII hex of snap[7:4], ASCII hex of snap[3:0], 0x0D, 0x0A.
REQ-012 Hex encoding SHALL map nibble 0-9 -> 0x30-0x39 and nibble A-F -> 0x41-0x46 (uppercase).
REQ-013 Each byte SHALL be sent 8N1: start bit 0, data bits LSB first, then stop bit 1, for 10 bit periods per byte.
REQ-014 Bytes SHALL be sent back-to-back, with the next start bit immediately following the previous stop bit, so a frame lasts exactly 40*DIV cycles.
REQ-015 The FSM SHALL use states IDLE, START, DATA, STOP and a 2-bit byte index 0..3, and a 3-bit bit index 0..7.
REQ-016 The FSM SHALL follow these transitions: START->DATA after DIV cycles; DATA->STOP after the 8th bit's DIV cycles; STOP->START when the byte index is < 3 (byte index increments); STOP->IDLE when the byte index is 3.
REQ-017 busy SHALL fall in the same cycle that the FSM re-enters IDLE, and tx SHALL remain 1 in IDLE.
REQ-018 Changes on leds during a frame SHALL NOT alter the frame in progress, because snap is frozen.
REQ-019 After the frame ends, if leds != last_sent, a new frame SHALL start at the first IDLE edge, with intermediate values coalesced and only the current value reported.
REQ-020 If leds returns to last_sent before the frame ends, no further frame SHALL be sent.
REQ-021 The baud counter SHALL be $clog2(DIV) bits wide, count 0..DIV-1, and wrap to 0 at each bit boundary, with no cumulative drift.

Reset
REQ-022 rst=1 SHALL immediately, without waiting for a clock edge, force tx=1, busy=0, state=IDLE, last_sent=0x00, snap=0x00, and clear all counters.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no partial-byte completion.
REQ-024 After reset release, any leds != 0x00 SHALL trigger a frame on the first clk edge.

Verification (CLK_FREQ=1000, BAUD=100, DIV=10)
REQ-025 The bench SHALL cover power-up: release rst with leds=0x1F -> tx low one cycle later, bytes 0x31,0x46,0x0D,0x0A decoded, busy high for exactly 400 cycles.
REQ-026 The bench SHALL cover no change: leds held at 0x00 after reset -> tx stays 1 and busy stays 0 for 1000 cycles.
REQ-027 The bench SHALL cover coalescing: during the frame for 0x1F, drive 0x3E then 0x7C -> the first frame reports "1F", and exactly one next frame reports "7C", starting 1 cycle after busy falls.
REQ-028 The bench SHALL cover revert: during the frame for 0x3E, drive 0x7C then back to 0x3E -> no second frame, and busy stays 0 afterwards.
REQ-029 The bench SHALL cover mid-frame reset: assert rst at cycle 150 of a frame -> tx=1 and busy=0 in the same cycle, and after release with leds=0xA5 a full frame "A5\r\n" is sent.
REQ-030 The bench SHALL check bit timing: every bit period measured on tx equals exactly 10 cycles, and the letter-nibble check 0xC9 encodes as 0x43,0x39.

Source files
------------

// File: rtl/led_uart_reporter.sv
// led_uart_reporter: watches an 8-bit LED pattern and, whenever it differs
// from the last reported value, sends "HH\r\n" (uppercase hex) over an
// 8N1 UART. Changes that arrive mid-frame are coalesced into one follow-up
// report of the newest value.
module led_uart_reporter #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] leds,
    output logic       tx,
    output logic       busy
);

    // Clock cycles per UART bit; must be at least 2.
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [1:0]      r_byte_idx;
    logic [7:0]      r_snap;
    logic [7:0]      r_last_sent;
    logic            r_tx;
    logic            r_busy;

    state_t          w_state_nx;
    logic [CW-1:0]   w_cnt_nx;
    logic [2:0]      w_bit_idx_nx;
    logic [1:0]      w_byte_idx_nx;
    logic [7:0]      w_snap_nx;
    logic [7:0]      w_last_sent_nx;
    logic [7:0]      w_char_nx;
    logic            w_tx_nx;
    logic            w_busy_nx;
    logic            w_bit_end;

    // Nibble to uppercase ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] v;
        if (nib < 4'd10) begin
            v = 8'h30 + {4'h0, nib};
        end else begin
            v = 8'h37 + {4'h0, nib};
        end
        return v;
    endfunction

    // Character at a given position of the report frame.
    function automatic logic [7:0] frame_char(input logic [7:0] snap,
                                              input logic [1:0] idx);
        logic [7:0] c;
        case (idx)
            2'd0:    c = hex_ascii(snap[7:4]);
            2'd1:    c = hex_ascii(snap[3:0]);
            2'd2:    c = 8'h0D;
            2'd3:    c = 8'h0A;
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

    assign w_bit_end = (r_cnt == CNT_MAX);

    // Next-state logic: baud counter, bit/byte indices and frame capture.
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_bit_idx_nx   = r_bit_idx;
        w_byte_idx_nx  = r_byte_idx;
        w_snap_nx      = r_snap;
        w_last_sent_nx = r_last_sent;
        case (r_state)
            IDLE: begin
                if (leds != r_last_sent) begin
                    w_state_nx     = START;
                    w_snap_nx      = leds;
                    w_last_sent_nx = leds;
                    w_cnt_nx       = CNT_ZERO;
                    w_bit_idx_nx   = 3'd0;
                    w_byte_idx_nx  = 2'd0;
                end else begin
                    w_state_nx     = IDLE;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_cnt_nx     = CNT_ZERO;
                    w_bit_idx_nx = 3'd0;
                    w_state_nx   = DATA;
                end else begin
                    w_cnt_nx     = r_cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_cnt_nx = CNT_ZERO;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nx = STOP;
                    end else begin
                        w_bit_idx_nx = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_ONE;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_cnt_nx = CNT_ZERO;
                    if (r_byte_idx == 2'd3) begin
                        w_state_nx    = IDLE;
                        w_byte_idx_nx = 2'd0;
                    end else begin
                        w_state_nx    = START;
                        w_byte_idx_nx = r_byte_idx + 2'd1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nx    = IDLE;
                w_cnt_nx      = CNT_ZERO;
                w_bit_idx_nx  = 3'd0;
                w_byte_idx_nx = 2'd0;
            end
        endcase
    end

    // Output decode from the next state so tx/busy can be registered
    // without adding a cycle of latency.
    always_comb begin
        w_char_nx = frame_char(w_snap_nx, w_byte_idx_nx);
        w_tx_nx   = 1'b1;
        w_busy_nx = 1'b1;
        case (w_state_nx)
            IDLE: begin
                w_tx_nx   = 1'b1;
                w_busy_nx = 1'b0;
            end
            START:   w_tx_nx = 1'b0;
            DATA:    w_tx_nx = w_char_nx[w_bit_idx_nx];
            STOP:    w_tx_nx = 1'b1;
            default: begin
                w_tx_nx   = 1'b1;
                w_busy_nx = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= CNT_ZERO;
            r_bit_idx   <= 3'd0;
            r_byte_idx  <= 2'd0;
            r_snap      <= 8'h00;
            r_last_sent <= 8'h00;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_bit_idx   <= w_bit_idx_nx;
            r_byte_idx  <= w_byte_idx_nx;
            r_snap      <= w_snap_nx;
            r_last_sent <= w_last_sent_nx;
            r_tx        <= w_tx_nx;
            r_busy      <= w_busy_nx;
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;

endmodule

// File: tb/tb_led_uart_reporter.sv
// Self-checking bench for led_uart_reporter (CLK_FREQ=1000, BAUD=100 -> 10
// cycles per bit). A frame-level reference model predicts tx/busy every
// cycle; a UART decoder and busy-run monitor pin literal expectations.
module tb_led_uart_reporter;

    localparam int BITC  = 10;
    localparam int FRAME = 40 * BITC;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [7:0] leds = 8'h00;
    logic       tx;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    led_uart_reporter #(.CLK_FREQ(1000), .BAUD(100)) dut (
        .clk  (clk),
        .rst  (rst),
        .leds (leds),
        .tx   (tx),
        .busy (busy)
    );

    // 10-unit clock period
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    bit         m_active = 1'b0;
    int         m_t      = 0;
    logic [7:0] m_last   = 8'h00;
    logic [7:0] m_snap   = 8'h00;

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h41 + ({4'h0, n} - 8'd10);
    endfunction

    // Expected line level at cycle t (0..399) of a frame reporting v.
    function automatic logic model_tx(input logic [7:0] v, input int t);
        int         bi;
        int         pos;
        logic [7:0] ch;
        bi  = t / BITC;
        pos = bi % 10;
        case (bi / 10)
            0: ch = hexc(v[7:4]);
            1: ch = hexc(v[3:0]);
            2: ch = 8'h0D;
            default: ch = 8'h0A;
        endcase
        if (pos == 0)      return 1'b0;
        else if (pos == 9) return 1'b1;
        else               return ch[pos-1];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_t      = 0;
            m_last   = 8'h00;
            m_snap   = 8'h00;
        end else if (m_active) begin
            m_t++;
            if (m_t == FRAME) m_active = 1'b0;
        end else if (leds != m_last) begin
            m_last   = leds;
            m_snap   = leds;
            m_active = 1'b1;
            m_t      = 0;
        end
    end

    // ---------------- monitor: compare, runs, decoder ----------------
    int         cyc      = 0;
    int         n_rises  = 0;
    int         n_falls  = 0;
    int         rise_cyc = 0;
    int         fall_cyc = 0;
    int         run_len  = 0;
    int         gap      = 0;
    int         n_txlow  = 0;
    logic       busy_prev = 1'b0;
    logic       tx_prev   = 1'b1;
    bit         dec_on   = 1'b0;
    int         dec_cnt  = 0;
    logic [7:0] dec_byte = 8'h00;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        logic exp_tx;
        cyc++;
        exp_tx = m_active ? model_tx(m_snap, m_t) : 1'b1;
        chk("model_tx", 32'(tx), 32'(exp_tx));
        chk("model_busy", 32'(busy), 32'(m_active));
        if (tx == 1'b0) n_txlow++;
        if (busy && !busy_prev) begin
            n_rises++;
            gap      = cyc - fall_cyc;
            rise_cyc = cyc;
        end
        if (!busy && busy_prev) begin
            n_falls++;
            run_len  = cyc - rise_cyc;
            fall_cyc = cyc;
        end
        if (busy && (tx !== tx_prev))
            chk("bit_edge_align", 32'((cyc - rise_cyc) % BITC), 32'd0);
        busy_prev = busy;
        tx_prev   = tx;
        if (rst) begin
            dec_on = 1'b0;
        end else if (!dec_on) begin
            if (tx == 1'b0) begin
                dec_on  = 1'b1;
                dec_cnt = 0;
            end
        end else begin
            dec_cnt++;
            if (dec_cnt == 5) begin
                chk("start_bit", 32'(tx), 32'd0);
            end else if (dec_cnt >= 15 && dec_cnt <= 85 && ((dec_cnt - 15) % 10) == 0) begin
                dec_byte[(dec_cnt - 15) / 10] = tx;
            end else if (dec_cnt == 95) begin
                chk("stop_bit", 32'(tx), 32'd1);
                rx_q.push_back(dec_byte);
                dec_on = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_rise(input string nm, input int maxc);
        int r0 = n_rises;
        int k  = 0;
        while (n_rises == r0 && k < maxc) begin tick(1); k++; end
        chk(nm, 32'(n_rises != r0), 32'd1);
    endtask

    task automatic wait_fall(input string nm, input int maxc);
        int f0 = n_falls;
        int k  = 0;
        while (n_falls == f0 && k < maxc) begin tick(1); k++; end
        chk(nm, 32'(n_falls != f0), 32'd1);
    endtask

    task automatic chk_bytes(input string nm, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] e[4];
        e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3;
        chk({nm, "_nbytes"}, 32'(rx_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < rx_q.size()) chk($sformatf("%s_byte%0d", nm, i), 32'(rx_q[i]), 32'(e[i]));
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin
        int r0;
        int l0;
        rst  = 1'b1;
        leds = 8'h00;
        tick(3);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);

        // No change: leds stay 0x00 after reset.
        rst = 1'b0;
        r0  = n_rises;
        l0  = n_txlow;
        tick(1000);
        chk("nochange_frames", 32'(n_rises - r0), 32'd0);
        chk("nochange_txlow", 32'(n_txlow - l0), 32'd0);

        // Power-up with 0x1F, coalescing 0x3E then 0x7C mid-frame.
        rst  = 1'b1;
        leds = 8'h1F;
        tick(2);
        rx_q.delete();
        r0  = n_rises;
        rst = 1'b0;
        #1;
        chk("pwrup_pre_edge_tx", 32'(tx), 32'd1);
        @(posedge clk);
        #1;
        chk("pwrup_tx_low", 32'(tx), 32'd0);
        chk("pwrup_busy", 32'(busy), 32'd1);
        #1;
        tick(100);
        leds = 8'h3E;
        tick(100);
        leds = 8'h7C;
        wait_fall("f1_end", FRAME + 20);
        chk("f1_busy_len", 32'(run_len), 32'(FRAME));
        chk_bytes("f1", 8'h31, 8'h46, 8'h0D, 8'h0A);
        rx_q.delete();
        wait_rise("f2_start", 10);
        chk("coalesce_gap", 32'(gap), 32'd1);
        wait_fall("f2_end", FRAME + 20);
        chk("f2_busy_len", 32'(run_len), 32'(FRAME));
        chk_bytes("f2", 8'h37, 8'h43, 8'h0D, 8'h0A);
        tick(300);
        chk("coalesce_frames", 32'(n_rises - r0), 32'd2);

        // Revert: 0x3E frame, leds go 0x7C then back to 0x3E.
        rx_q.delete();
        leds = 8'h3E;
        wait_rise("rev_start", 10);
        tick(50);
        leds = 8'h7C;
        tick(100);
        leds = 8'h3E;
        r0 = n_rises;
        wait_fall("rev_end", FRAME + 20);
        chk_bytes("rev", 8'h33, 8'h45, 8'h0D, 8'h0A);
        tick(600);
        chk("revert_frames", 32'(n_rises - r0), 32'd0);
        chk("revert_busy", 32'(busy), 32'd0);

        // Letter nibble encoding 0xC9.
        rx_q.delete();
        leds = 8'hC9;
        wait_rise("c9_start", 10);
        wait_fall("c9_end", FRAME + 20);
        chk("c9_busy_len", 32'(run_len), 32'(FRAME));
        chk_bytes("c9", 8'h43, 8'h39, 8'h0D, 8'h0A);

        // Mid-frame reset at cycle ~150, then 0xA5 after release.
        leds = 8'h55;
        wait_rise("mid_start", 10);
        tick(150);
        rst = 1'b1;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        #1;
        leds = 8'hA5;
        tick(3);
        rx_q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("a5_tx_low", 32'(tx), 32'd0);
        #1;
        wait_fall("a5_end", FRAME + 20);
        chk("a5_busy_len", 32'(run_len), 32'(FRAME));
        chk_bytes("a5", 8'h41, 8'h35, 8'h0D, 8'h0A);

        // Random traffic with occasional resets, checked by the model.
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                tick(2);
                rst = 1'b0;
            end
            leds = 8'($urandom);
            tick($urandom_range(1, 700));
        end
        tick(2 * FRAME + 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
